// File: rtl/lut_sram_chain.sv
// rtl/lut_sram_chain.sv - LUT configuration memory loaded through a serial daisy chain.
// Define LUT_SRAM_CHAIN_REG_OUT_EN to register the read port.
module lut_sram_chain #(
    parameter int ADDR_BITS  = 4,
    parameter int DATA_WIDTH = 2,
    parameter int MEM_SIZE   = 2**ADDR_BITS,
    parameter int CHAIN_LEN  = MEM_SIZE*DATA_WIDTH
) (
    input  logic                  config_clk,
    input  logic                  config_rst_n,
    input  logic [ADDR_BITS-1:0]  addr,
    output logic [DATA_WIDTH-1:0] out,
    input  logic                  config_en,
    input  logic                  config_in,
    output logic                  config_out,
    output logic                  config_done,
    input  logic                  write_en,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  write_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN+1);
    localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0]  chain_q, chain_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  write_err_q, write_err_d;
    logic [IDX_W-1:0]      ridx, widx;
    logic [DATA_WIDTH-1:0] rd_data;

    assign config_done = (count_q == CNT_FULL);
    assign config_out  = chain_q[CHAIN_LEN-1];
    assign write_err   = write_err_q;

    always_comb begin
        ridx    = IDX_W'(addr) * IDX_W'(DATA_WIDTH);
        widx    = IDX_W'(waddr) * IDX_W'(DATA_WIDTH);
        rd_data = chain_q[ridx +: DATA_WIDTH];
    end

    // Shifting has priority over the run-time write port; a colliding write is dropped and flagged.
    always_comb begin
        chain_d     = chain_q;
        count_d     = count_q;
        write_err_d = write_err_q;
        if (config_en) begin
            chain_d = {chain_q[CHAIN_LEN-2:0], config_in};
            if (count_q != CNT_FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (write_en && config_done) begin
            chain_d[widx +: DATA_WIDTH] = data_in;
        end
        if (write_en && (config_en || !config_done)) begin
            write_err_d = 1'b1;
        end
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            chain_q     <= '0;
            count_q     <= '0;
            write_err_q <= 1'b0;
        end else begin
            chain_q     <= chain_d;
            count_q     <= count_d;
            write_err_q <= write_err_d;
        end
    end

`ifdef LUT_SRAM_CHAIN_REG_OUT_EN
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = rd_data;
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
`else
    assign out = rd_data;
`endif

endmodule

// File: tb/tb_lut_sram_chain.sv
// tb/tb_lut_sram_chain.sv - scoreboard bench for lut_sram_chain (ADDR_BITS=4, DATA_WIDTH=2).
module tb_lut_sram_chain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] addr = '0;
    logic [1:0] out;
    logic       config_en = 1'b0;
    logic       config_in = 1'b0;
    logic       config_out;
    logic       config_done;
    logic       write_en = 1'b0;
    logic [3:0] waddr = '0;
    logic [1:0] data_in = '0;
    logic       write_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic        dq[$];
    logic [31:0] img;

    lut_sram_chain #(.ADDR_BITS(4), .DATA_WIDTH(2)) dut (
        .config_clk(clk), .config_rst_n(rst_n), .addr(addr), .out(out),
        .config_en(config_en), .config_in(config_in), .config_out(config_out),
        .config_done(config_done), .write_en(write_en), .waddr(waddr),
        .data_in(data_in), .write_err(write_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] entry(input logic [31:0] w, input int e);
        logic [31:0] t;
        t = w;
        return t[e*2 +: 2];
    endfunction

    task automatic read_check(input string tag, input int a, input logic [1:0] e);
        addr = 4'(a);
        exp_q.push_back({30'd0, e});
`ifdef LUT_SRAM_CHAIN_REG_OUT_EN
        tick();
`endif
        #1;
        check(tag, {30'd0, out}, exp_q.pop_front());
    endtask

    task automatic check_all(input string tag, input logic [31:0] w);
        for (int e = 0; e < 16; e++) read_check(tag, e, entry(w, e));
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        config_en = 1'b0;
        write_en = 1'b0;
        dq.delete();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Shift w[n-1:0] MSB first; optionally compare config_out against the bit sent 32 shifts earlier.
    task automatic shift_bits(input logic [31:0] w, input int n, input bit cmp);
        for (int i = n - 1; i >= 0; i--) begin
            if (cmp) begin
                if (dq.size() == 0) check("config_out_underrun", 32'd1, 32'd0);
                else check("config_out_replay", {31'd0, config_out}, {31'd0, dq.pop_front()});
            end
            dq.push_back(w[i]);
            config_en = 1'b1;
            config_in = w[i];
            tick();
        end
        config_en = 1'b0;
    endtask

    task automatic write_entry(input int a, input logic [1:0] d);
        write_en = 1'b1;
        waddr = 4'(a);
        data_in = d;
        tick();
        write_en = 1'b0;
    endtask

    initial begin
        do_reset();
        check_all("reset_out", 32'd0);
        check("reset_config_out", {31'd0, config_out}, 32'd0);
        check("reset_done", {31'd0, config_done}, 32'd0);
        check("reset_err", {31'd0, write_err}, 32'd0);

        img = 32'hA5C3_0F96;
        shift_bits(img >> 1, 31, 1'b0);
        check("done_before_32", {31'd0, config_done}, 32'd0);
        shift_bits(img, 1, 1'b0);
        check("done_after_32", {31'd0, config_done}, 32'd1);
        read_check("load_addr0", 0, 2'b10);
        read_check("load_addr15", 15, 2'b10);
        check_all("load_image", img);

`ifdef LUT_SRAM_CHAIN_REG_OUT_EN
        addr = 4'd0;
        tick();
        addr = 4'd15;
        #1;
        check("regout_old", {30'd0, out}, {30'd0, entry(img, 0)});
        tick();
        check("regout_new", {30'd0, out}, {30'd0, entry(img, 15)});
`endif

        img = 32'hFFFF_0000;
        shift_bits(img, 32, 1'b1);
        check("done_holds", {31'd0, config_done}, 32'd1);
        check_all("pass_image", img);

        write_entry(5, 2'b01);
        img[11:10] = 2'b01;
        check_all("legal_write", img);
        check("legal_err", {31'd0, write_err}, 32'd0);

        config_en = 1'b1;
        config_in = 1'b1;
        write_en = 1'b1;
        waddr = 4'd0;
        data_in = 2'b11;
        tick();
        config_en = 1'b0;
        write_en = 1'b0;
        img = {img[30:0], 1'b1};
        check_all("collide_shift", img);
        check("collide_err", {31'd0, write_err}, 32'd1);

        do_reset();
        check("rst_err_clear", {31'd0, write_err}, 32'd0);
        write_entry(3, 2'b11);
        check_all("early_write_dropped", 32'd0);
        check("early_err", {31'd0, write_err}, 32'd1);
        img = $urandom;
        shift_bits(img, 32, 1'b0);
        check("reload_done", {31'd0, config_done}, 32'd1);
        write_entry(3, 2'b11);
        img[7:6] = 2'b11;
        check_all("late_write", img);
        check("err_sticky", {31'd0, write_err}, 32'd1);

        do_reset();
        shift_bits(32'hFFFFF, 20, 1'b0);
        check("midload_done", {31'd0, config_done}, 32'd0);
        do_reset();
        check("midreset_done", {31'd0, config_done}, 32'd0);
        check("midreset_cfg_out", {31'd0, config_out}, 32'd0);
        img = 32'h1234_5678;
        shift_bits(img >> 1, 31, 1'b0);
        check("restart_31", {31'd0, config_done}, 32'd0);
        shift_bits(img, 1, 1'b0);
        check("restart_32", {31'd0, config_done}, 32'd1);
        check_all("restart_image", img);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lut_sram_chain.md
# lut_sram_chain

Parametrised LUT configuration memory with multi-bit entries, serial daisy-chain configuration, load tracking and a run-time single-entry write port. It is the configuration/storage element behind each fracturable LUT in the CLB. Entries are loaded by shifting a bitstream through `config_in` → `config_out`, and are read by the LUT address inputs. A load counter reports when the full image has arrived, and a sticky error flags illegal run-time writes.

## Interface
Parameters:
- `ADDR_BITS`, 4: LUT address width.
- `DATA_WIDTH`, 2: bits per entry (fracturable outputs).
- `MEM_SIZE`, `2**ADDR_BITS`: number of entries.
- `CHAIN_LEN`, `MEM_SIZE*DATA_WIDTH`: total configuration bits. Derived; do not override.

Ports:
- `config_clk`, in, 1: the single clock. All state updates on its rising edge.
- `config_rst_n`, in, 1: asynchronous, active-low reset.
- `addr`, in, `ADDR_BITS`: read address.
- `out`, out, `DATA_WIDTH`: entry at `addr`.
- `config_en`, in, 1: shift-enable for the configuration chain.
- `config_in`, in, 1: serial configuration bit.
- `config_out`, out, 1: serial pass-through to the next block in the chain.
- `config_done`, out, 1: full image loaded.
- `write_en`, in, 1: run-time entry write.
- `waddr`, in, `ADDR_BITS`: write address.
- `data_in`, in, `DATA_WIDTH`: write data.
- `write_err`, out, 1: sticky illegal-write flag.

## Operation
- **Storage:** flat chain `chain[CHAIN_LEN-1:0]`. Entry `i` bit `b` = `chain[i*DATA_WIDTH+b]`.
- **Read:** `out = chain[addr*DATA_WIDTH +: DATA_WIDTH]`. Combinational unless the macro in Configuration is defined.
- **Shift (`config_en`=1):**
  - `chain <= {chain[CHAIN_LEN-2:0], config_in}`.
  - The first bit shifted ends in `chain[CHAIN_LEN-1]` after `CHAIN_LEN` shifts.
  - `config_out = chain[CHAIN_LEN-1]`, combinational from the current state.
- **Load counter:**
  - Width `$clog2(CHAIN_LEN+1)`.
  - Increments on each shift and saturates at `CHAIN_LEN`.
  - `config_done = (count == CHAIN_LEN)`.
  - Cleared only by reset. Deasserting `config_en` mid-load pauses the count; it does not clear it.
  - Shifting after `config_done` continues to update the chain and pass bits through; the count holds.
- **Write:**
  - Legal write: `write_en`=1, `config_en`=0, `config_done`=1. Writes `data_in` into entry `waddr`; other entries are unchanged.
  - Illegal write: `write_en`=1 while `config_en`=1 or `config_done`=0. Ignored (no storage change) and sets `write_err`.
- **Simultaneous `config_en` and `write_en`:** the shift wins and `write_err` sets.
- **`write_err`:** sticky until reset.
- **Reset (async assert, sync release):**
  - `chain`=0, count=0.
  - `config_done`=0, `write_err`=0.
  - `out`=0, `config_out`=0.

## Timing
- A shift or write takes effect on the rising edge where it is sampled. New data is visible on `out` immediately after that edge (combinational read).
- `config_done` rises after the edge of the `CHAIN_LEN`-th shift.
- `config_out` presents the bit shifted in `CHAIN_LEN` cycles earlier, so downstream blocks see a pure `CHAIN_LEN`-cycle delay line.
- Read-during-write to the same address returns the old entry until the edge, then the new one. No bypass.
- Reset asserted mid-load aborts the load. The count restarts from 0 and `config_done`=0 until a full `CHAIN_LEN` shifts complete.

## Configuration
- Macro: `LUT_SRAM_CHAIN_REG_OUT_EN`.
- **Defined:**
  - `out` is registered on `config_clk`, giving read latency 1 cycle after an `addr` change.
  - The register resets to 0.
  - A write or shift becomes visible on `out` one edge after it lands.
- **Undefined:** `out` is purely combinational with zero latency.
- `config_out`, `config_done` and `write_err` are identical in both builds.

## Test plan
- **Reset state:** reset, then release → `out`=0, `config_out`=0, `config_done`=0, `write_err`=0 for every `addr`.
- **Full serial load:** `ADDR_BITS`=4, `DATA_WIDTH`=2. Shift the 32-bit image 0xA5C3_0F96, MSB first.
  - `config_done` rises after exactly the 32nd edge.
  - `addr`=0 → `out`=2'b10.
  - `addr`=15 → `out`=2'b10.
- **Daisy-chain pass-through:** shift 32 more bits of 0xFFFF_0000 → `config_out` replays 0xA5C3_0F96 MSB first, and `config_done` stays 1.
- **Legal write:** after load, `write_en`=1, `waddr`=5, `data_in`=2'b01 for one cycle → `addr`=5 reads 01, all other entries unchanged, `write_err`=0.
- **Illegal writes:**
  - Before `config_done`: write `waddr`=3, `data_in`=2'b11 → storage unchanged, `write_err`=1, and it stays 1 through later legal writes until reset.
  - Separately, `config_en` and `write_en` together → the shift occurs, the write is dropped, `write_err`=1.
- **Mid-load reset and registered output:** assert reset after 20 shifts → `config_done` remains 0 until 32 further shifts.
  - With `LUT_SRAM_CHAIN_REG_OUT_EN`: an `addr` change reflects on `out` exactly one edge later.
